// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, cycle-count helpers and frame parity.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StShift,
    StAck,
    StWaitIdle
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int unsigned FrameBits = 11;

  function automatic int unsigned inhibit_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge detector on the synced level.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  // [0],[1] synchronize; [2] holds the previous synced level. Idle lines are high.
  logic [2:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], line};
    end
  end

  assign level = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, requests to send, shifts one byte out
// on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned INHIBIT_US   = 100,
  parameter int unsigned SETUP_CYCLES = 10,
  parameter int unsigned TIMEOUT_MS   = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned InhibitCyc = inhibit_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TimeoutCyc = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_MS);
  localparam int unsigned CntW       = $clog2(TimeoutCyc);

  localparam logic [CntW-1:0] InhibitLast = CntW'(InhibitCyc - 1);
  localparam logic [CntW-1:0] SetupLast   = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCyc - 1);
  localparam logic [3:0]      LastShift   = 4'(FrameBits - 2);

  ps2_state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [FrameBits-2:0] frame_q, frame_d;
  logic                 data_oe_q, data_oe_d;
  logic                 ack_ok_q, ack_ok_d;
  logic                 init_q;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic accept, timeout, line_idle;

  ps2_sync_edge u_sync_clk (
    .clock (clock),
    .reset (reset),
    .line  (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clock (clock),
    .reset (reset),
    .line  (ps2_data_in),
    .level (data_lvl),
    .fall  (data_fall_unused)
  );

  // init_q keeps tx_ready low while reset is asserted even though the state is already IDLE.
  assign accept    = (state_q == StIdle) && init_q && tx_valid;
  assign timeout   = (state_q inside {StShift, StAck, StWaitIdle}) && (cnt_q == TimeoutLast);
  assign line_idle = clk_lvl && data_lvl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StInhibit;
      StInhibit:  if (cnt_q == InhibitLast) state_d = StStart;
      StStart:    if (cnt_q == SetupLast) state_d = StShift;
      StShift: begin
        if (timeout) state_d = StIdle;
        else if (clk_fall && (bit_cnt_q == LastShift)) state_d = StAck;
      end
      StAck: begin
        if (timeout) state_d = StIdle;
        else if (clk_fall) state_d = StWaitIdle;
      end
      StWaitIdle: if (timeout || line_idle) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_ready    = (state_q == StIdle) && init_q;
    busy        = (state_q != StIdle);
    ps2_clk_oe  = (state_q == StInhibit) || (state_q == StStart);
    ps2_data_oe = (state_q == StStart) || ((state_q == StShift) && data_oe_q && !timeout);
    tx_done     = (state_q == StWaitIdle) && !timeout && line_idle && ack_ok_q;
    tx_error    = timeout || ((state_q == StWaitIdle) && line_idle && !ack_ok_q);
  end

  // One counter serves inhibit, setup and the release-to-completion timeout.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          data_oe_d = 1'b0;
        end
      end
      StInhibit: if (cnt_q == InhibitLast) cnt_d = '0;
      StStart: begin
        data_oe_d = 1'b1;
        if (cnt_q == SetupLast) cnt_d = '0;
      end
      StShift: begin
        if (!timeout && clk_fall) begin
          data_oe_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StAck:      if (!timeout && clk_fall) ack_ok_d = ~data_lvl;
      StWaitIdle: ;
      default:    cnt_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
      ack_ok_q  <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
      ack_ok_q  <= ack_ok_d;
      init_q    <= 1'b1;
    end
  end

endmodule
